// File: rtl/slurm16_cpu_hazard_pipeline.sv
// -----------------------------------------------------------------------------
// slurm16_cpu_hazard_pipeline
//
// Purpose:
//   Carries the hazard tags of each instruction (destination register tag plus
//   a "writes flags" bit) from pipeline slot p0 through p1, p2 and p3.
//   The tags held in p1..p3 are fed back to the p0 hazard checker.
//   The checker's verdicts (hazard_1..3) then decide whether p0 is held and a
//   bubble is inserted into p1.
//   A global freeze (stall_in) holds every stage.
//   A taken branch in p2 (flush) kills p0/p1 while the branch itself keeps
//   advancing, so its link-register tag is preserved.
//
// Parameters:
//   REGISTER_BITS     width of a register tag; tag 0 (R0) means "no hazard".
//
// Ports:
//   CLK               clock, rising-edge active
//   RSTb              asynchronous active-low reset, clears all stages
//   valid0            p0 holds a real instruction
//   hazard_reg0       destination tag of the p0 instruction
//   modifies_flags0   p0 instruction writes flags
//   hazard_1..3       p0 depends on the instruction in p1 / p2 / p3
//   stall_in          global freeze; all stages hold
//   flush             branch taken in p2; kill p0 and p1
//   hazard_reg1..3    tags currently held in p1 / p2 / p3
//   modifies_flags1..3 flag bits currently held in p1 / p2 / p3
//   stall_p0          hold fetch/p0 this cycle
//   bubble_p1         the instruction entering p1 this cycle is a NOP
//
// Optional build feature (macro SLURM16_HAZARD_PERF_EN):
//   perf_clear          synchronous clear of the stall counter
//   hazard_stall_cycles saturating count of edges spent in a hazard stall
// -----------------------------------------------------------------------------
module slurm16_cpu_hazard_pipeline #(
  parameter int REGISTER_BITS = 7
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     valid0,
  input  logic [REGISTER_BITS-1:0] hazard_reg0,
  input  logic                     modifies_flags0,
  input  logic                     hazard_1,
  input  logic                     hazard_2,
  input  logic                     hazard_3,
  input  logic                     stall_in,
  input  logic                     flush,
`ifdef SLURM16_HAZARD_PERF_EN
  input  logic                     perf_clear,
  output logic [15:0]              hazard_stall_cycles,
`endif
  output logic [REGISTER_BITS-1:0] hazard_reg1,
  output logic [REGISTER_BITS-1:0] hazard_reg2,
  output logic [REGISTER_BITS-1:0] hazard_reg3,
  output logic                     modifies_flags1,
  output logic                     modifies_flags2,
  output logic                     modifies_flags3,
  output logic                     stall_p0,
  output logic                     bubble_p1
);

  localparam int NUM_STAGES = 3;

  // A stage entry always moves as one {tag, flags} unit.
  typedef struct packed {
    logic [REGISTER_BITS-1:0] tag;
    logic                     flags;
  } slot_t;

  localparam slot_t BUBBLE = '{tag: '0, flags: 1'b0};

  slot_t stage_reg  [1:NUM_STAGES];
  slot_t stage_next [1:NUM_STAGES];
  slot_t incoming;

  logic hz;
  logic advance;

  // ---------------------------------------------------------------------------
  // Hazard decision and handshake outputs
  // ---------------------------------------------------------------------------
  assign hz      = valid0 & (hazard_1 | hazard_2 | hazard_3);
  assign advance = ~stall_in;

  // A flush redirects fetch, so it must not be blocked by a hazard that
  // belongs to an instruction that is about to be killed.
  assign stall_p0  = stall_in | (hz & ~flush);

  // Whatever enters p1 on an advancing edge is a NOP when p0 is killed,
  // held for a hazard, or simply empty.  Under a freeze nothing enters p1.
  assign bubble_p1 = ~stall_in & (flush | hz | ~valid0);

  assign incoming = '{tag: hazard_reg0, flags: modifies_flags0};

  // ---------------------------------------------------------------------------
  // Next-state of each stage, assuming the pipeline advances this edge.
  // Stage 1 takes the p0 instruction unless a bubble is being inserted.
  // Stage 2 is killed by a flush (it holds the instruction behind the branch).
  // Stage 3 always takes stage 2: on a flush that is the branch itself, whose
  // link-register write must still be tracked.
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_next[1] = bubble_p1 ? BUBBLE : incoming;
    stage_next[2] = flush ? BUBBLE : stage_reg[1];
    stage_next[3] = stage_reg[2];
  end

  // ---------------------------------------------------------------------------
  // Stage registers.  Whatever leaves p3 is retired, so it is simply dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 1; i <= NUM_STAGES; i++) begin
        stage_reg[i] <= BUBBLE;
      end
    end else if (advance) begin
      for (int i = 1; i <= NUM_STAGES; i++) begin
        stage_reg[i] <= stage_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Feedback taps for the p0 hazard checker
  // ---------------------------------------------------------------------------
  assign hazard_reg1     = stage_reg[1].tag;
  assign hazard_reg2     = stage_reg[2].tag;
  assign hazard_reg3     = stage_reg[3].tag;
  assign modifies_flags1 = stage_reg[1].flags;
  assign modifies_flags2 = stage_reg[2].flags;
  assign modifies_flags3 = stage_reg[3].flags;

`ifdef SLURM16_HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Hazard stall counter: counts edges on which the pipeline advanced with a
  // bubble caused purely by a register/flag hazard (not a freeze, not a flush).
  // ---------------------------------------------------------------------------
  logic        perf_event;
  logic [15:0] stall_count_reg;

  assign perf_event = hz & ~flush & ~stall_in;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      stall_count_reg <= 16'h0000;
    end else if (perf_clear) begin
      stall_count_reg <= 16'h0000;
    end else if (perf_event && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'h0001;
    end
  end

  assign hazard_stall_cycles = stall_count_reg;
`endif

endmodule

// File: tb/tb_slurm16_cpu_hazard_pipeline.sv
module tb_slurm16_cpu_hazard_pipeline;

  localparam int RB = 7;

  logic          CLK = 1'b0;
  logic          RSTb;
  logic          valid0;
  logic [RB-1:0] hazard_reg0;
  logic          modifies_flags0;
  logic          hazard_1, hazard_2, hazard_3;
  logic          stall_in, flush;
  logic [RB-1:0] hazard_reg1, hazard_reg2, hazard_reg3;
  logic          modifies_flags1, modifies_flags2, modifies_flags3;
  logic          stall_p0, bubble_p1;
`ifdef SLURM16_HAZARD_PERF_EN
  logic          perf_clear;
  logic [15:0]   hazard_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  slurm16_cpu_hazard_pipeline #(.REGISTER_BITS(RB)) dut (
    .CLK             (CLK),
    .RSTb            (RSTb),
    .valid0          (valid0),
    .hazard_reg0     (hazard_reg0),
    .modifies_flags0 (modifies_flags0),
    .hazard_1        (hazard_1),
    .hazard_2        (hazard_2),
    .hazard_3        (hazard_3),
    .stall_in        (stall_in),
    .flush           (flush),
`ifdef SLURM16_HAZARD_PERF_EN
    .perf_clear          (perf_clear),
    .hazard_stall_cycles (hazard_stall_cycles),
`endif
    .hazard_reg1     (hazard_reg1),
    .hazard_reg2     (hazard_reg2),
    .hazard_reg3     (hazard_reg3),
    .modifies_flags1 (modifies_flags1),
    .modifies_flags2 (modifies_flags2),
    .modifies_flags3 (modifies_flags3),
    .stall_p0        (stall_p0),
    .bubble_p1       (bubble_p1)
  );

  // Reference model: the three pipeline slots as an array of {tag, flags}.
  logic [RB-1:0] m_tag [1:3];
  logic          m_fl  [1:3];

  task automatic model_clear();
    for (int i = 1; i <= 3; i++) begin
      m_tag[i] = '0;
      m_fl[i]  = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    valid0 = 1'b0; hazard_reg0 = '0; modifies_flags0 = 1'b0;
    hazard_1 = 1'b0; hazard_2 = 1'b0; hazard_3 = 1'b0;
    stall_in = 1'b0; flush = 1'b0;
  endtask

  // One clock edge; the model follows the pipeline rules with the inputs that
  // were applied before the edge.  Returns 1 ns after the edge.
  task automatic tick();
    logic hzv;
    hzv = valid0 && (hazard_1 || hazard_2 || hazard_3);
    @(posedge CLK);
    if (!RSTb) begin
      model_clear();
    end else if (!stall_in) begin
      m_tag[3] = m_tag[2]; m_fl[3] = m_fl[2];
      if (flush || hzv) begin
        if (flush) begin
          m_tag[2] = '0; m_fl[2] = 1'b0;
        end else begin
          m_tag[2] = m_tag[1]; m_fl[2] = m_fl[1];
        end
        m_tag[1] = '0; m_fl[1] = 1'b0;
      end else begin
        m_tag[2] = m_tag[1]; m_fl[2] = m_fl[1];
        m_tag[1] = valid0 ? hazard_reg0 : '0;
        m_fl[1]  = valid0 ? modifies_flags0 : 1'b0;
      end
    end
    #1;
  endtask

  // Accept one plain instruction into p1 (no hazards).
  task automatic push(input logic [RB-1:0] tag, input logic fl);
    idle_inputs();
    valid0 = 1'b1; hazard_reg0 = tag; modifies_flags0 = fl;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
`ifdef SLURM16_HAZARD_PERF_EN
    perf_clear = 1'b0;
`endif
    RSTb = 1'b0;
    model_clear();
    #3;
    total++;
    if ({hazard_reg1, hazard_reg2, hazard_reg3} !== '0 ||
        {modifies_flags1, modifies_flags2, modifies_flags3} !== 3'b000) begin
      bad++;
      $display("FAIL reset_tags: got r=%0d/%0d/%0d f=%b%b%b required all 0",
               hazard_reg1, hazard_reg2, hazard_reg3,
               modifies_flags1, modifies_flags2, modifies_flags3);
    end
    total++;
    if (stall_p0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall: got %b required 0", stall_p0);
    end
    @(posedge CLK); #1;
    RSTb = 1'b1;
    @(posedge CLK); #1;
    $display("txn reset: r=%0d/%0d/%0d", hazard_reg1, hazard_reg2, hazard_reg3);
  endtask

  task automatic test_stream();
    logic [RB-1:0] tags [4];
    logic          fls  [4];
    logic [RB-1:0] e1, e2, e3;
    logic          f1, f2, f3;
    tags = '{7'd3, 7'd4, 7'd5, 7'd6};
    fls  = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      push(tags[i], fls[i]);
      e1 = tags[i];                    f1 = fls[i];
      e2 = (i >= 1) ? tags[i-1] : '0;  f2 = (i >= 1) ? fls[i-1] : 1'b0;
      e3 = (i >= 2) ? tags[i-2] : '0;  f3 = (i >= 2) ? fls[i-2] : 1'b0;
      total++;
      if (hazard_reg1 !== e1 || hazard_reg2 !== e2 || hazard_reg3 !== e3 ||
          modifies_flags1 !== f1 || modifies_flags2 !== f2 || modifies_flags3 !== f3) begin
        bad++;
        $display("FAIL stream_%0d: got r=%0d/%0d/%0d f=%b%b%b required r=%0d/%0d/%0d f=%b%b%b",
                 i, hazard_reg1, hazard_reg2, hazard_reg3,
                 modifies_flags1, modifies_flags2, modifies_flags3, e1, e2, e3, f1, f2, f3);
      end
      $display("txn stream %0d: tag=%0d r=%0d/%0d/%0d", i, tags[i], hazard_reg1, hazard_reg2, hazard_reg3);
    end
  endtask

  task automatic test_raw_p1();
    push(7'd5, 1'b0);
    idle_inputs();
    valid0 = 1'b1; hazard_reg0 = 7'd9; hazard_1 = 1'b1;
    #1;
    total++;
    if (stall_p0 !== 1'b1 || bubble_p1 !== 1'b1) begin
      bad++;
      $display("FAIL raw_p1_ctrl: got stall=%b bubble=%b required 1 1", stall_p0, bubble_p1);
    end
    tick();
    total++;
    if (hazard_reg1 !== 7'd0 || hazard_reg2 !== 7'd5) begin
      bad++;
      $display("FAIL raw_p1_shift: got r1=%0d r2=%0d required 0 5", hazard_reg1, hazard_reg2);
    end
    hazard_1 = 1'b0;
    tick();
    total++;
    if (hazard_reg1 !== 7'd9 || hazard_reg2 !== 7'd0 || hazard_reg3 !== 7'd5) begin
      bad++;
      $display("FAIL raw_p1_resume: got r=%0d/%0d/%0d required 9/0/5", hazard_reg1, hazard_reg2, hazard_reg3);
    end
    $display("txn raw_p1: r=%0d/%0d/%0d", hazard_reg1, hazard_reg2, hazard_reg3);
  endtask

  task automatic test_triple_stall();
    int stall_cnt;
    logic [RB-1:0] exp_r [3][3];
    exp_r = '{'{7'd0, 7'd7, 7'd1}, '{7'd0, 7'd0, 7'd7}, '{7'd0, 7'd0, 7'd0}};
    push(7'd1, 1'b0);
    push(7'd7, 1'b1);
    stall_cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      idle_inputs();
      valid0 = 1'b1; hazard_reg0 = 7'd8;
      hazard_1 = (k == 1); hazard_2 = (k == 2); hazard_3 = (k == 3);
      #1;
      if (stall_p0 === 1'b1) stall_cnt++;
      tick();
      total++;
      if (hazard_reg1 !== exp_r[k-1][0] || hazard_reg2 !== exp_r[k-1][1] ||
          hazard_reg3 !== exp_r[k-1][2]) begin
        bad++;
        $display("FAIL triple_step%0d: got r=%0d/%0d/%0d required %0d/%0d/%0d", k,
                 hazard_reg1, hazard_reg2, hazard_reg3, exp_r[k-1][0], exp_r[k-1][1], exp_r[k-1][2]);
      end
    end
    idle_inputs();
    valid0 = 1'b1; hazard_reg0 = 7'd8;
    #1;
    total++;
    if (stall_cnt != 3 || stall_p0 !== 1'b0) begin
      bad++;
      $display("FAIL triple_count: got stalls=%0d stall_now=%b required 3 0", stall_cnt, stall_p0);
    end
    tick();
    total++;
    if (hazard_reg1 !== 7'd8) begin
      bad++;
      $display("FAIL triple_release: got r1=%0d required 8", hazard_reg1);
    end
    $display("txn triple_stall: stalls=%0d r1=%0d", stall_cnt, hazard_reg1);
  endtask

  task automatic test_flush_link();
    push(7'd4, 1'b0);
    push(7'd15, 1'b1);
    push(7'd2, 1'b0);
    idle_inputs();
    valid0 = 1'b1; hazard_reg0 = 7'd12; hazard_2 = 1'b1; flush = 1'b1;
    #1;
    total++;
    if (stall_p0 !== 1'b0 || bubble_p1 !== 1'b1) begin
      bad++;
      $display("FAIL flush_ctrl: got stall=%b bubble=%b required 0 1", stall_p0, bubble_p1);
    end
    tick();
    total++;
    if (hazard_reg1 !== 7'd0 || hazard_reg2 !== 7'd0 || hazard_reg3 !== 7'd15 ||
        modifies_flags1 !== 1'b0 || modifies_flags2 !== 1'b0 || modifies_flags3 !== 1'b1) begin
      bad++;
      $display("FAIL flush_stages: got r=%0d/%0d/%0d f=%b%b%b required 0/0/15 f=001",
               hazard_reg1, hazard_reg2, hazard_reg3, modifies_flags1, modifies_flags2, modifies_flags3);
    end
    idle_inputs();
    $display("txn flush_link: r=%0d/%0d/%0d", hazard_reg1, hazard_reg2, hazard_reg3);
  endtask

  task automatic test_stall_freeze();
    push(7'd5, 1'b1);
    push(7'd4, 1'b0);
    push(7'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      valid0 = 1'b1; hazard_reg0 = 7'd20; stall_in = 1'b1;
      hazard_1 = (i % 2 == 0); flush = (i == 1 || i == 3);
      #1;
      total++;
      if (stall_p0 !== 1'b1 || bubble_p1 !== 1'b0) begin
        bad++;
        $display("FAIL freeze_ctrl_%0d: got stall=%b bubble=%b required 1 0", i, stall_p0, bubble_p1);
      end
      tick();
      total++;
      if (hazard_reg1 !== 7'd3 || hazard_reg2 !== 7'd4 || hazard_reg3 !== 7'd5 ||
          modifies_flags1 !== 1'b1 || modifies_flags2 !== 1'b0 || modifies_flags3 !== 1'b1) begin
        bad++;
        $display("FAIL freeze_hold_%0d: got r=%0d/%0d/%0d required 3/4/5", i,
                 hazard_reg1, hazard_reg2, hazard_reg3);
      end
    end
    idle_inputs();
    $display("txn stall_freeze: r=%0d/%0d/%0d", hazard_reg1, hazard_reg2, hazard_reg3);
  endtask

  task automatic test_reset_mid_stall();
    push(7'd11, 1'b1);
    idle_inputs();
    valid0 = 1'b1; hazard_reg0 = 7'd13; hazard_1 = 1'b1;
    #1;
    total++;
    if (stall_p0 !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: got stall=%b required 1", stall_p0);
    end
    RSTb = 1'b0;
    idle_inputs();
    #1;
    model_clear();
    total++;
    if ({hazard_reg1, hazard_reg2, hazard_reg3} !== '0 || modifies_flags1 !== 1'b0 ||
        stall_p0 !== 1'b0 || bubble_p1 !== 1'b1) begin
      bad++;
      $display("FAIL midreset_clear: got r=%0d/%0d/%0d f1=%b stall=%b bubble=%b required 0/0/0 0 0 1",
               hazard_reg1, hazard_reg2, hazard_reg3, modifies_flags1, stall_p0, bubble_p1);
    end
    tick();
    RSTb = 1'b1;
    $display("txn reset_mid_stall: r1=%0d", hazard_reg1);
  endtask

  task automatic test_random();
    logic hzv, exp_stall, exp_bubble;
    for (int n = 0; n < 300; n++) begin
      valid0          = ($urandom_range(3) != 0);
      hazard_reg0     = RB'($urandom);
      modifies_flags0 = $urandom_range(1);
      hazard_1        = ($urandom_range(5) == 0);
      hazard_2        = ($urandom_range(5) == 0);
      hazard_3        = ($urandom_range(5) == 0);
      stall_in        = ($urandom_range(7) == 0);
      flush           = ($urandom_range(9) == 0);
      #1;
      hzv        = valid0 && (hazard_1 || hazard_2 || hazard_3);
      exp_stall  = stall_in || (hzv && !flush);
      exp_bubble = !stall_in && (flush || hzv || !valid0);
      total++;
      if (stall_p0 !== exp_stall || bubble_p1 !== exp_bubble) begin
        bad++;
        $display("FAIL rand_ctrl_%0d: got stall=%b bubble=%b required %b %b",
                 n, stall_p0, bubble_p1, exp_stall, exp_bubble);
      end
      tick();
      total++;
      if (hazard_reg1 !== m_tag[1] || hazard_reg2 !== m_tag[2] || hazard_reg3 !== m_tag[3] ||
          modifies_flags1 !== m_fl[1] || modifies_flags2 !== m_fl[2] || modifies_flags3 !== m_fl[3]) begin
        bad++;
        $display("FAIL rand_stage_%0d: got r=%0d/%0d/%0d f=%b%b%b required r=%0d/%0d/%0d f=%b%b%b", n,
                 hazard_reg1, hazard_reg2, hazard_reg3, modifies_flags1, modifies_flags2, modifies_flags3,
                 m_tag[1], m_tag[2], m_tag[3], m_fl[1], m_fl[2], m_fl[3]);
      end
      $display("txn rand %0d: v=%b t=%0d h=%b%b%b s=%b f=%b -> r=%0d/%0d/%0d", n, valid0, hazard_reg0,
               hazard_1, hazard_2, hazard_3, stall_in, flush, hazard_reg1, hazard_reg2, hazard_reg3);
    end
    idle_inputs();
  endtask

`ifdef SLURM16_HAZARD_PERF_EN
  task automatic test_perf();
    idle_inputs();
    perf_clear = 1'b1; tick(); perf_clear = 1'b0;
    valid0 = 1'b1; hazard_1 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    stall_in = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (hazard_stall_cycles !== 16'd3) begin
      bad++;
      $display("FAIL perf_count: got %0d required 3", hazard_stall_cycles);
    end
    perf_clear = 1'b1; tick(); perf_clear = 1'b0;
    total++;
    if (hazard_stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL perf_clear: got %0d required 0", hazard_stall_cycles);
    end
    for (int i = 0; i < 65535; i++) tick();
    total++;
    if (hazard_stall_cycles !== 16'hFFFF) begin
      bad++;
      $display("FAIL perf_full: got %h required ffff", hazard_stall_cycles);
    end
    tick();
    total++;
    if (hazard_stall_cycles !== 16'hFFFF) begin
      bad++;
      $display("FAIL perf_sat: got %h required ffff", hazard_stall_cycles);
    end
    idle_inputs();
    $display("txn perf: count=%h", hazard_stall_cycles);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_raw_p1();
    test_triple_stall();
    test_flush_link();
    test_stall_freeze();
    test_reset_mid_stall();
    test_random();
`ifdef SLURM16_HAZARD_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
